// File: rtl/ntt_op_sequencer.sv
// Command sequencer for the radix-2 NTT address/control FSM: issues conf codes
// for NTT/PWM/INTT (or the chained polymul), drains the wen pipeline, reports done/err.
module ntt_op_sequencer #(
  parameter int DRAIN_CYCLES = 9,
  parameter int TIMEOUT      = 6000,
  parameter int CNT_W        = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic [3:0] i_done_flag,
  output logic [2:0] o_conf,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_cur_op
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_cur_op, w_cur_op_nxt;
  logic             r_chain, w_chain_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic             r_err, w_err_nxt;
  logic [2:0]       r_conf, w_conf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cur_op <= 2'd0;
      r_chain  <= 1'b0;
      r_tmo    <= 1'b0;
      r_err    <= 1'b0;
      r_conf   <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cur_op <= w_cur_op_nxt;
      r_chain  <= w_chain_nxt;
      r_tmo    <= w_tmo_nxt;
      r_err    <= w_err_nxt;
      r_conf   <= w_conf_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cur_op_nxt = r_cur_op;
    w_chain_nxt  = r_chain;
    w_tmo_nxt    = r_tmo;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt  = S_RUN;
          w_chain_nxt  = (i_op == 2'd3);
          w_cur_op_nxt = (i_op == 2'd3) ? 2'd0 : i_op;
          w_tmo_nxt    = 1'b0;
          w_err_nxt    = 1'b0;
          w_cnt_nxt    = '0;
        end
      end
      S_RUN: begin
        if (i_done_flag[r_cur_op]) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          // Timeout still drains so the FSM pipeline is left clean.
          w_state_nxt = S_DRAIN;
          w_tmo_nxt   = 1'b1;
          w_chain_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_cnt_nxt = '0;
          if (r_chain && (r_cur_op < 2'd2)) begin
            w_cur_op_nxt = r_cur_op + 2'd1;
            w_state_nxt  = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
            w_err_nxt   = r_tmo;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land registered with it.
  always_comb begin
    w_conf_nxt = 3'd0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_RUN: begin
        w_conf_nxt = {1'b0, w_cur_op_nxt} + 3'd1;
        w_busy_nxt = 1'b1;
      end
      S_DRAIN: begin
        w_conf_nxt = (w_cur_op_nxt == 2'd2) ? 3'd5 : 3'd4;
        w_busy_nxt = 1'b1;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: w_conf_nxt = 3'd0;
    endcase
  end

  assign o_conf   = r_conf;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_cur_op = r_cur_op;

endmodule

// File: tb/tb_ntt_op_sequencer.sv
// Scoreboard bench for ntt_op_sequencer: expected conf segments and done/err
// records are queued at stimulus time and matched as the DUT emits them.
module tb_ntt_op_sequencer;

  localparam int TIMEOUT = 6000;
  localparam int DRAIN   = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [1:0] i_op;
  logic [3:0] i_done_flag;
  logic [2:0] o_conf;
  logic       o_busy, o_done, o_err;
  logic [1:0] o_cur_op;

  ntt_op_sequencer #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TIMEOUT), .CNT_W(13)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_done_flag(i_done_flag),
    .o_conf(o_conf), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cur_op(o_cur_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] conf;
    int         len;
    logic [1:0] op;
  } seg_t;

  seg_t segq[$];
  bit   errq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  bit   en_mon = 1'b1;
  bit   junk = 1'b0;
  int   lat[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_op(input int o, input int l);
    seg_t s;
    s.conf = 3'(o + 1); s.len = (l == 0) ? TIMEOUT : l; s.op = 2'(o);
    segq.push_back(s);
    s.conf = (o == 2) ? 3'd5 : 3'd4; s.len = DRAIN;
    segq.push_back(s);
  endtask

  // Behavioural FSM: raises its done bit on the lat-th cycle of an active code.
  logic [2:0] rsp_last = 3'd0;
  int         rsp_cc = 0;
  always @(negedge clk) begin
    if (o_conf != rsp_last) rsp_cc = 0; else rsp_cc++;
    rsp_last = o_conf;
    if (o_conf >= 3'd1 && o_conf <= 3'd3) begin
      int c;
      c = int'(o_conf) - 1;
      if (lat[c] > 0 && rsp_cc == lat[c] - 1) i_done_flag = 4'(1 << c);
      else i_done_flag = junk ? (4'hF & ~4'(1 << c)) : 4'h0;
    end else if (o_conf == 3'd5) i_done_flag = 4'b0001;
    else if (o_conf == 3'd4) i_done_flag = junk ? 4'b0111 : 4'h0;
    else i_done_flag = 4'h0;
  end

  // Monitor: compress conf into runs and match runs and done pulses.
  logic [2:0] m_prev = 3'd0;
  int         m_len = 0;
  logic [1:0] m_op = 2'd0;
  logic       m_pdone = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      m_prev = 3'd0; m_len = 0; m_pdone = 1'b0;
    end else begin
      if (o_conf != m_prev) begin
        if (m_prev != 3'd0 && en_mon) begin
          if (segq.size() == 0) chk("seg_extra", 32'(m_prev), 0);
          else begin
            seg_t s;
            s = segq.pop_front();
            chk("seg_conf", 32'(m_prev), 32'(s.conf));
            chk("seg_len", 32'(m_len), 32'(s.len));
            chk("seg_cur_op", 32'(m_op), 32'(s.op));
          end
        end
        m_prev = o_conf; m_len = 1; m_op = o_cur_op;
      end else m_len++;
      if (o_done) begin
        n_done++;
        chk("done_width", 32'(m_pdone), 0);
        chk("done_busy", 32'(o_busy), 0);
        chk("done_conf", 32'(o_conf), 0);
        if (en_mon) begin
          if (errq.size() == 0) chk("done_extra", 1, 0);
          else chk("done_err", 32'(o_err), 32'(errq.pop_front()));
        end
      end
      m_pdone = o_done;
    end
  end

  task automatic start_op(input logic [1:0] op);
    @(negedge clk);
    i_start = 1'b1; i_op = op;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #1;
      if (n_done >= target) break;
    end
    chk("done_wait", 32'(n_done), 32'(target));
  endtask

  initial begin
    int nd;
    rst = 1'b1; i_start = 1'b0; i_op = 2'd0;
    lat[0] = 0; lat[1] = 0; lat[2] = 0;
    #1;
    chk("rst_conf", 32'(o_conf), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_cur_op", 32'(o_cur_op), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Plain NTT, flag after one full 5120-cycle pass.
    lat[0] = 5120; exp_op(0, 5120); errq.push_back(1'b0);
    start_op(2'd0);
    chk("ntt_conf", 32'(o_conf), 1);
    wait_done(1);
    chk("ntt_err", 32'(o_err), 0);

    // Chained polymul with junk flags on the unrelated bits.
    junk = 1'b1; lat[0] = 20; lat[1] = 7; lat[2] = 33;
    exp_op(0, 20); exp_op(1, 7); exp_op(2, 33); errq.push_back(1'b0);
    start_op(2'd3);
    wait_done(2);

    // INTT with bit0 (and others) asserted while INTT runs.
    lat[2] = 25; exp_op(2, 25); errq.push_back(1'b0);
    start_op(2'd2);
    chk("intt_conf", 32'(o_conf), 3);
    wait_done(3);
    junk = 1'b0;

    // INTT that never finishes: timeout then drain, err with done.
    lat[2] = 0; exp_op(2, 0); errq.push_back(1'b1);
    start_op(2'd2);
    wait_done(4);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(o_err), 1);

    // start hammered during a PWM run; this start also clears err.
    lat[1] = 40; exp_op(1, 40); errq.push_back(1'b0);
    @(negedge clk);
    i_start = 1'b1; i_op = 2'd1;
    @(negedge clk);
    chk("err_clr", 32'(o_err), 0);
    for (int i = 0; i < 2000; i++) begin
      if (o_done) break;
      i_op = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("spam_cur_op", 32'(o_cur_op), 1);
    end
    i_start = 1'b0;
    wait_done(5);
    repeat (5) @(negedge clk);
    #1;
    chk("spam_single_done", 32'(n_done), 5);
    chk("spam_idle", 32'(o_busy), 0);

    // Asynchronous reset mid-NTT, then a clean restart.
    en_mon = 1'b0; lat[0] = 0;
    start_op(2'd0);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_conf", 32'(o_conf), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_conf", 32'(o_conf), 0);
    en_mon = 1'b1;
    nd = n_done;
    lat[0] = 11; exp_op(0, 11); errq.push_back(1'b0);
    start_op(2'd0);
    wait_done(nd + 1);

    repeat (4) @(negedge clk);
    chk("segq_empty", 32'(segq.size()), 0);
    chk("errq_empty", 32'(errq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
